// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command-side master for alu_16bit_low_power.
// Buffers commands in a small FIFO, issues them one at a time to the ALU, captures the
// result and flags, and returns them on a valid/ready response port. It also owns the ALU
// power policy: alu_enable rises only around bursts of work and drops after an idle timeout.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_a, cmd_b, cmd_op carry the command
//   alu_a, alu_b, alu_op         registered operands/opcode to the ALU (change only on issue)
//   alu_enable                   registered ALU clock-gate enable
//   alu_result/zero/carry        ALU outputs, sampled ALU_LAT cycles after the operand cycle
//   rsp_valid/rsp_ready          response handshake; rsp_result, rsp_zero, rsp_carry held
//   busy                         FSM awake or FIFO non-empty
//
// Optional build macro ALU_ISS_STATS_EN adds stat_ops (responses accepted) and stat_gated
// (cycles with alu_enable low), both 16-bit saturating counters.

module alu_cmd_issuer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned OP_W      = 3,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned WAKE_CYC  = 1,
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned IDLE_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_enable,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              busy
`ifdef ALU_ISS_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_gated
`endif
);

    localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(CMD_DEPTH + 1);
    localparam int unsigned ENT_W = 2 * DATA_W + OP_W;
    localparam int unsigned TMR_W = 16;

    typedef enum logic [2:0] {StSleep, StWake, StExec, StResp, StIdle} state_e;

    state_e             state_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [ENT_W-1:0]   fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;
    logic               fifo_nonempty;
    logic [DATA_W-1:0]  head_a;
    logic [DATA_W-1:0]  head_b;
    logic [OP_W-1:0]    head_op;

    // Held low during reset so no command is accepted while the block is being cleared.
    assign cmd_ready     = !rst && (count_q != CNT_W'(CMD_DEPTH));
    assign push          = cmd_valid && cmd_ready;
    assign fifo_nonempty = (count_q != '0);
    assign {head_a, head_b, head_op} = fifo_mem[rd_ptr_q];
    assign busy          = (state_q != StSleep) || fifo_nonempty;

    // Pop exactly on the transitions that enter EXEC; the FSM loads the head in the same edge.
    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            StWake:  pop = (tmr_q == TMR_W'(WAKE_CYC - 1));
            StResp:  pop = rsp_valid && rsp_ready && fifo_nonempty;
            StIdle:  pop = fifo_nonempty;
            default: pop = 1'b0;
        endcase
    end

    // FIFO storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StSleep;
            tmr_q      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            alu_enable <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
        end else begin
            // Operand isolation: the ALU inputs move only when a command is issued.
            if (pop) begin
                alu_a  <= head_a;
                alu_b  <= head_b;
                alu_op <= head_op;
            end
            unique case (state_q)
                StSleep: begin
                    if (fifo_nonempty) begin
                        state_q    <= StWake;
                        alu_enable <= 1'b1;
                        tmr_q      <= '0;
                    end
                end
                StWake: begin
                    if (pop) begin
                        state_q <= StExec;
                        tmr_q   <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                StExec: begin
                    // tmr_q counts edges after the operand cycle; capture after ALU_LAT of them.
                    if (tmr_q == TMR_W'(ALU_LAT)) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_carry  <= alu_carry;
                        rsp_valid  <= 1'b1;
                        state_q    <= StResp;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                StResp: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        tmr_q     <= '0;
                        if (fifo_nonempty) begin
                            state_q <= StExec;
                        end else if (IDLE_HOLD > 0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q    <= StSleep;
                            alu_enable <= 1'b0;
                        end
                    end
                end
                StIdle: begin
                    if (fifo_nonempty) begin
                        state_q <= StExec;
                        tmr_q   <= '0;
                    end else if (tmr_q == TMR_W'(IDLE_HOLD - 1)) begin
                        state_q    <= StSleep;
                        alu_enable <= 1'b0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_q    <= StSleep;
                    alu_enable <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ISS_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_gated <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (stat_ops != 16'hFFFF)) begin
                stat_ops <= stat_ops + 16'd1;
            end
            if (!alu_enable && (stat_gated != 16'hFFFF)) begin
                stat_gated <= stat_gated + 16'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
